mod_enc_in_buffer: RTL and testbench

Input stage of the AES-256 encryption datapath: collects 32-bit plaintext words from the host bus, packs four of them into one 16-byte state and holds completed states in a small block FIFO. It sits directly upstream of the initial AddRoundKey stage and drives its `p` operand with a valid/ready handshake. Input word transfer and round processing are decoupled, so the next block can be loaded while the current one is encrypting.

---
 rtl/aes_enc_pkg.sv | 11 +
 rtl/mod_enc_in_buffer.sv | 112 +++++++++++
 tb/tb_mod_enc_in_buffer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_enc_pkg.sv
// Shared types and sizes for the AES-256 encryption datapath.
// A state is 16 bytes; byte i of a state is bits [8*i +: 8] of its flat 128-bit value.
package aes_enc_pkg;

    localparam int N      = 16;
    localparam int NWORDS = 4;
    localparam int NROWS  = 4;

    typedef logic [N-1:0][7:0] aes_state_t;

endpackage

// File: rtl/mod_enc_in_buffer.sv
// Plaintext input stage: packs four 32-bit words into a 16-byte state and
// queues finished states in an NSLOT-deep block FIFO feeding AddRoundKey.
module mod_enc_in_buffer
    import aes_enc_pkg::*;
#(
    parameter int NSLOT = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              din,
    output logic                     out_valid,
    input  logic                     out_ready,
    output aes_state_t               o,
    output logic [$clog2(NSLOT):0]   fill
);

    localparam int PW = $clog2(NSLOT);
    localparam int CW = $clog2(NSLOT) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(NSLOT);

    logic [1:0]    word_cnt_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    aes_state_t    slot_r [NSLOT];

    logic [1:0]    word_cnt_s;
    logic [PW-1:0] wr_ptr_s;
    logic [PW-1:0] rd_ptr_s;
    logic [CW-1:0] count_s;
    logic          accept_s;
    logic          pop_s;
    logic          last_s;

    // Handshake status is decoded from registered occupancy only, so a pop
    // in the same cycle cannot reopen in_ready while full.
    assign in_ready  = (count_r != FULL_CNT);
    assign out_valid = (count_r != {CW{1'b0}});
    assign o         = slot_r[rd_ptr_r];
    assign fill      = count_r;

    assign accept_s = in_valid && in_ready;
    assign pop_s    = out_valid && out_ready;
    assign last_s   = accept_s && (word_cnt_r == 2'd3);

    // Next-state for packing position, FIFO pointers and occupancy; clear wins.
    always_comb begin
        word_cnt_s = word_cnt_r;
        wr_ptr_s   = wr_ptr_r;
        rd_ptr_s   = rd_ptr_r;
        count_s    = count_r;
        if (clear) begin
            word_cnt_s = 2'd0;
            wr_ptr_s   = {PW{1'b0}};
            rd_ptr_s   = {PW{1'b0}};
            count_s    = {CW{1'b0}};
        end else begin
            if (accept_s) begin
                word_cnt_s = word_cnt_r + 2'd1;
            end else begin
                word_cnt_s = word_cnt_r;
            end
            if (last_s) begin
                wr_ptr_s = wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            case ({last_s, pop_s})
                2'b10:   count_s = count_r + CW'(1);
                2'b01:   count_s = count_r - CW'(1);
                default: count_s = count_r;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_cnt_r <= 2'd0;
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else begin
            word_cnt_r <= word_cnt_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
        end
    end

    // Slot storage: each accepted word lands in bytes 4w..4w+3 of the write slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < NSLOT; s++) begin
                slot_r[s] <= '0;
            end
        end else if (accept_s && !clear) begin
            for (int j = 0; j < 4; j++) begin
                slot_r[wr_ptr_r][{word_cnt_r, 2'(j)}] <= din[8*j +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mod_enc_in_buffer.sv
// Self-checking bench for mod_enc_in_buffer: directed scenarios plus random
// streaming, checked against a word/block queue model of the buffer.
module tb_mod_enc_in_buffer;
    import aes_enc_pkg::*;

    localparam int NSLOT = 2;

    logic        clk;
    logic        resetn;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] din;
    logic        out_valid;
    logic        out_ready;
    aes_state_t  o;
    logic [1:0]  fill;

    int total = 0;
    int bad   = 0;

    logic [127:0] mq[$];
    logic [31:0]  pw[$];

    mod_enc_in_buffer #(.NSLOT(NSLOT)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .fill      (fill)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(mq.size() != 0));
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(mq.size() != NSLOT));
        chk({tag, "_fill"}, 128'(fill), 128'(mq.size()));
        if (mq.size() != 0) begin
            chk({tag, "_o"}, 128'(o), mq[0]);
        end
    endtask

    // One clock: drive inputs now, model the edge, check outputs #1 after it.
    task automatic cyc(input logic v, input logic [31:0] d, input logic r, output logic acc);
        logic pop;
        in_valid  = v;
        din       = d;
        out_ready = r;
        acc = v && (mq.size() != NSLOT);
        pop = r && (mq.size() != 0);
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (acc) begin
            pw.push_back(d);
            if (pw.size() == 4) begin
                mq.push_back({pw[3], pw[2], pw[1], pw[0]});
                pw.delete();
            end
        end
        check_all("cyc");
    endtask

    task automatic send(input logic [31:0] d, input logic r);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            cyc(1'b1, d, r, acc);
            n++;
        end
        chk("send_accepted", 128'(acc), 128'(1'b1));
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic r);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, r, acc);
        out_ready = 1'b0;
    endtask

    initial begin
        logic        acc;
        logic [31:0] w [12];
        logic [31:0] b [4];
        int          k;
        int          sent;
        int          ncyc;
        logic        v;
        logic        r;
        logic [31:0] rw;

        resetn = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("rst_fill", 128'(fill), 128'(0));
        chk("rst_o", 128'(o), 128'(0));
        resetn = 1'b1;

        // Single block
        send(32'h33221100, 1'b0);
        send(32'h77665544, 1'b0);
        send(32'hbbaa9988, 1'b0);
        chk("sb_not_yet_valid", 128'(out_valid), 128'(1'b0));
        send(32'hffeeddcc, 1'b0);
        chk("sb_out_valid", 128'(out_valid), 128'(1'b1));
        chk("sb_o0", 128'(o[0]), 128'(8'h00));
        chk("sb_o5", 128'(o[5]), 128'(8'h55));
        chk("sb_o15", 128'(o[15]), 128'(8'hff));
        chk("sb_fill", 128'(fill), 128'(1));
        idle(1, 1'b1);
        chk("sb_drained", 128'(out_valid), 128'(1'b0));

        // Full / backpressure
        for (int i = 0; i < 12; i++) w[i] = $urandom;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            cyc(1'b1, w[k], 1'b0, acc);
            if (acc) k++;
        end
        chk("full_fill", 128'(fill), 128'(2));
        chk("full_in_ready", 128'(in_ready), 128'(1'b0));
        chk("full_head", 128'(o), {w[3], w[2], w[1], w[0]});
        cyc(1'b1, w[k], 1'b1, acc);
        if (acc) k++;
        chk("full_reopen", 128'(in_ready), 128'(1'b1));
        chk("full_second", 128'(o), {w[7], w[6], w[5], w[4]});
        while (k < 12) begin
            send(w[k], 1'b0);
            k++;
        end
        idle(3, 1'b1);
        chk("full_empty", 128'(fill), 128'(0));

        // Simultaneous block completion and pop
        for (int i = 0; i < 4; i++) send($urandom, 1'b0);
        for (int i = 0; i < 4; i++) b[i] = $urandom;
        for (int i = 0; i < 3; i++) send(b[i], 1'b0);
        cyc(1'b1, b[3], 1'b1, acc);
        out_ready = 1'b0;
        chk("sim_fill", 128'(fill), 128'(1));
        chk("sim_o", 128'(o), {b[3], b[2], b[1], b[0]});

        // Clear with in_valid high: the word in that cycle is dropped
        send(32'hdeadbeef, 1'b0);
        send(32'hcafef00d, 1'b0);
        clear = 1'b1; in_valid = 1'b1; din = 32'h12345678;
        @(posedge clk);
        #1;
        clear = 1'b0; in_valid = 1'b0;
        mq.delete(); pw.delete();
        chk("clr_fill", 128'(fill), 128'(0));
        chk("clr_out_valid", 128'(out_valid), 128'(1'b0));
        for (int i = 0; i < 4; i++) b[i] = $urandom;
        for (int i = 0; i < 4; i++) send(b[i], 1'b0);
        chk("clr_block", 128'(o), {b[3], b[2], b[1], b[0]});
        idle(1, 1'b1);

        // Asynchronous reset pulse mid-block
        send(32'h0badcafe, 1'b0);
        send(32'h11111111, 1'b0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("arst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("arst_fill", 128'(fill), 128'(0));
        chk("arst_o", 128'(o), 128'(0));
        mq.delete(); pw.delete();
        #2 resetn = 1'b1;
        for (int i = 0; i < 4; i++) b[i] = $urandom;
        for (int i = 0; i < 4; i++) send(b[i], 1'b0);
        chk("arst_block", 128'(o), {b[3], b[2], b[1], b[0]});
        chk("arst_byte0", 128'(o[0]), 128'(b[0][7:0]));
        idle(1, 1'b1);

        // Random streaming
        sent = 0; ncyc = 0; rw = $urandom;
        while (sent < 1000 && ncyc < 20000) begin
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 6);
            cyc(v, rw, r, acc);
            if (acc) begin
                sent++;
                rw = $urandom;
            end
            ncyc++;
        end
        chk("rand_all_sent", 128'(sent), 128'(1000));
        idle(4, 1'b1);
        chk("rand_drained", 128'(fill), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
